// File: rtl/bfp16_accum.sv
// ============================================================================
// Module   : bfp16_accum
// Brief    : Streaming BFP16 accumulator for a systolic-array PE; sums product
//            beats into one result per vector, valid/ready on both sides.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module bfp16_accum #(
  parameter int K_LEN = 0,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      out_data,
  output logic [CNT_W-1:0] beat_cnt
);

  localparam int unsigned         C_KM1    = (K_LEN > 0) ? K_LEN - 1 : 0;
  localparam logic [CNT_W-1:0]    C_K_LAST = CNT_W'(C_KM1);
  localparam logic                C_AUTO   = (K_LEN > 0);

  logic [15:0]      r_acc;
  logic [15:0]      r_out_data;
  logic             r_out_valid;
  logic [CNT_W-1:0] r_cnt;

  logic             w_in_ready;
  logic             w_accept;
  logic             w_terminal;
  logic [15:0]      w_sum;

  // Truncating BFP16 add; subnormals flush to zero, specials resolve first.
  function automatic logic [15:0] fadd(input logic [15:0] a, input logic [15:0] b);
    logic        a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    logic        a_big, s_big;
    logic [7:0]  e_big, e_sml, d;
    logic [10:0] m_big, m_sml;
    logic [11:0] s;
    logic [3:0]  sh;
    logic [6:0]  f;
    logic signed [9:0] e;
    int          p;
    logic [15:0] r;
    a_nan  = (a[14:7] == 8'hFF) && (a[6:0] != 7'h0);
    b_nan  = (b[14:7] == 8'hFF) && (b[6:0] != 7'h0);
    a_inf  = (a[14:7] == 8'hFF) && (a[6:0] == 7'h0);
    b_inf  = (b[14:7] == 8'hFF) && (b[6:0] == 7'h0);
    a_zero = (a[14:7] == 8'h00);
    b_zero = (b[14:7] == 8'h00);
    r = 16'h0000;
    if (a_nan || b_nan || (a_inf && b_inf && (a[15] != b[15]))) begin
      r = 16'h7FC0;
    end else if (a_inf) begin
      r = {a[15], 8'hFF, 7'h00};
    end else if (b_inf) begin
      r = {b[15], 8'hFF, 7'h00};
    end else if (a_zero && b_zero) begin
      r = 16'h0000;
    end else if (a_zero) begin
      r = b;
    end else if (b_zero) begin
      r = a;
    end else begin
      a_big = ({a[14:7], a[6:0]} >= {b[14:7], b[6:0]});
      s_big = a_big ? a[15]    : b[15];
      e_big = a_big ? a[14:7]  : b[14:7];
      e_sml = a_big ? b[14:7]  : a[14:7];
      m_big = a_big ? {1'b1, a[6:0], 3'b000} : {1'b1, b[6:0], 3'b000};
      m_sml = a_big ? {1'b1, b[6:0], 3'b000} : {1'b1, a[6:0], 3'b000};
      d     = e_big - e_sml;
      m_sml = (d >= 8'd11) ? 11'd0 : (m_sml >> d);
      if (a[15] == b[15]) s = {1'b0, m_big} + {1'b0, m_sml};
      else                s = {1'b0, m_big} - {1'b0, m_sml};
      p = 0;
      for (int i = 0; i <= 10; i++) begin
        if (s[i]) p = i;
      end
      sh = 4'(10 - p);
      if (s[11]) begin
        e = $signed({2'b00, e_big}) + 10'sd1;
        f = s[10:4];
      end else begin
        e = $signed({2'b00, e_big}) - $signed({6'b000000, sh});
        f = 7'((s[10:0] << sh) >> 3);
      end
      if (s == 12'd0)          r = 16'h0000;
      else if (e >= 10'sd255)  r = {s_big, 8'hFF, 7'h00};
      else if (e <= 10'sd0)    r = {s_big, 15'h0000};
      else                     r = {s_big, e[7:0], f};
    end
    return r;
  endfunction

  always_comb begin
    w_sum      = fadd(r_acc, in_data);
    w_in_ready = !r_out_valid || out_ready;
    w_accept   = in_valid && w_in_ready;
    w_terminal = w_accept && (in_last || (C_AUTO && (r_cnt == C_K_LAST)));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_acc       <= 16'h0000;
      r_out_data  <= 16'h0000;
      r_out_valid <= 1'b0;
      r_cnt       <= '0;
    end else begin
      if (w_terminal) begin
        r_out_data  <= w_sum;
        r_out_valid <= 1'b1;
        r_acc       <= 16'h0000;
        r_cnt       <= '0;
      end else begin
        if (w_accept) begin
          r_acc <= w_sum;
          r_cnt <= r_cnt + 1'b1;
        end
        if (r_out_valid && out_ready) r_out_valid <= 1'b0;
      end
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign beat_cnt  = r_cnt;

endmodule

`default_nettype wire

// File: tb/tb_bfp16_accum.sv
// ============================================================================
// Module   : tb_bfp16_accum
// Brief    : Directed self-checking bench for bfp16_accum (K_LEN=0 and 4).
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_bfp16_accum;

  logic        clk;
  logic        rst;

  logic        in_valid0, in_ready0, in_last0, out_valid0, out_ready0;
  logic [15:0] in_data0, out_data0;
  logic [15:0] beat_cnt0;

  logic        in_valid4, in_ready4, in_last4, out_valid4, out_ready4;
  logic [15:0] in_data4, out_data4;
  logic [15:0] beat_cnt4;

  int n_vec;
  int n_err;

  bfp16_accum #(.K_LEN(0), .CNT_W(16)) u_dut0 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid0), .in_ready(in_ready0), .in_data(in_data0), .in_last(in_last0),
    .out_valid(out_valid0), .out_ready(out_ready0), .out_data(out_data0), .beat_cnt(beat_cnt0)
  );

  bfp16_accum #(.K_LEN(4), .CNT_W(16)) u_dut4 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid4), .in_ready(in_ready4), .in_data(in_data4), .in_last(in_last4),
    .out_valid(out_valid4), .out_ready(out_ready4), .out_data(out_data4), .beat_cnt(beat_cnt4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One beat into the K_LEN=0 instance; returns just after the accepting edge.
  task automatic send0(input logic [15:0] d, input logic last);
    @(negedge clk);
    in_valid0 = 1'b1;
    in_data0  = d;
    in_last0  = last;
    @(posedge clk);
    #1;
    in_valid0 = 1'b0;
    in_last0  = 1'b0;
  endtask

  task automatic send4(input logic [15:0] d, input logic last);
    @(negedge clk);
    in_valid4 = 1'b1;
    in_data4  = d;
    in_last4  = last;
    @(posedge clk);
    #1;
    in_valid4 = 1'b0;
    in_last4  = 1'b0;
  endtask

  task automatic pair0(input string tag, input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] exp);
    send0(a, 1'b0);
    send0(b, 1'b1);
    check_eq({tag, "_valid"}, {31'd0, out_valid0}, 32'd1);
    check_eq({tag, "_data"}, {16'd0, out_data0}, {16'd0, exp});
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst = 1'b0;
    in_valid0 = 1'b0; in_data0 = 16'h0; in_last0 = 1'b0; out_ready0 = 1'b1;
    in_valid4 = 1'b0; in_data4 = 16'h0; in_last4 = 1'b0; out_ready4 = 1'b1;
    #12;
    check_eq("rst_out_valid", {31'd0, out_valid0}, 32'd0);
    check_eq("rst_out_data", {16'd0, out_data0}, 32'h0);
    check_eq("rst_beat_cnt", {16'd0, beat_cnt0}, 32'd0);
    check_eq("rst_in_ready", {31'd0, in_ready0}, 32'd1);
    @(negedge clk);
    rst = 1'b1;

    // 1 + 2 + 3 = 6
    send0(16'h3F80, 1'b0);
    check_eq("sum_cnt1", {16'd0, beat_cnt0}, 32'd1);
    check_eq("sum_nolat", {31'd0, out_valid0}, 32'd0);
    send0(16'h4000, 1'b0);
    send0(16'h4040, 1'b1);
    check_eq("sum_valid", {31'd0, out_valid0}, 32'd1);
    check_eq("sum_data", {16'd0, out_data0}, 32'h40C0);
    check_eq("sum_cnt_clr", {16'd0, beat_cnt0}, 32'd0);
    @(posedge clk);
    #1;
    check_eq("sum_valid_drop", {31'd0, out_valid0}, 32'd0);

    pair0("cancel", 16'h3F80, 16'hBF80, 16'h0000);
    pair0("ovf", 16'h7F7F, 16'h7F7F, 16'h7F80);
    pair0("inf_ninf", 16'h7F80, 16'hFF80, 16'h7FC0);
    pair0("nan", 16'h3F80, 16'h7FC1, 16'h7FC0);
    pair0("inf_fin", 16'hFF80, 16'h4000, 16'hFF80);
    pair0("sub_mix", 16'h4040, 16'hBF80, 16'h4000);
    pair0("align", 16'h4000, 16'h3E80, 16'h4010);

    send0(16'h0001, 1'b1);
    check_eq("subn_data", {16'd0, out_data0}, 32'h0000);
    // back-to-back single-beat vectors: valid must not bubble
    send0(16'h4000, 1'b1);
    check_eq("b2b_valid", {31'd0, out_valid0}, 32'd1);
    check_eq("b2b_data", {16'd0, out_data0}, 32'h4000);
    @(posedge clk);
    #1;

    // K_LEN=4 auto termination, two vectors back-to-back
    for (int i = 0; i < 4; i++) send4(16'h3F00, 1'b0);
    check_eq("k4_valid1", {31'd0, out_valid4}, 32'd1);
    check_eq("k4_data1", {16'd0, out_data4}, 32'h4000);
    check_eq("k4_cnt1", {16'd0, beat_cnt4}, 32'd0);
    for (int i = 0; i < 4; i++) send4(16'h3F80, 1'b0);
    check_eq("k4_data2", {16'd0, out_data4}, 32'h4080);
    send4(16'h3F80, 1'b0);
    send4(16'h3F80, 1'b1);
    check_eq("k4_early_data", {16'd0, out_data4}, 32'h4000);
    check_eq("k4_early_cnt", {16'd0, beat_cnt4}, 32'd0);
    send4(16'h3F80, 1'b0);
    check_eq("k4_restart_cnt", {16'd0, beat_cnt4}, 32'd1);

    // Backpressure
    out_ready0 = 1'b0;
    send0(16'h3F80, 1'b0);
    send0(16'h4000, 1'b0);
    send0(16'h4040, 1'b1);
    @(negedge clk);
    in_valid0 = 1'b1; in_data0 = 16'h3F80; in_last0 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_eq("bp_in_ready", {31'd0, in_ready0}, 32'd0);
      check_eq("bp_hold", {16'd0, out_data0}, 32'h40C0);
      check_eq("bp_cnt", {16'd0, beat_cnt0}, 32'd0);
    end
    out_ready0 = 1'b1;
    #1;
    check_eq("bp_release_ready", {31'd0, in_ready0}, 32'd1);
    @(posedge clk);
    #1;
    in_valid0 = 1'b0; in_last0 = 1'b0;
    check_eq("bp_next_valid", {31'd0, out_valid0}, 32'd1);
    check_eq("bp_next_data", {16'd0, out_data0}, 32'h3F80);
    @(posedge clk);
    #1;
    check_eq("bp_drop", {31'd0, out_valid0}, 32'd0);

    // Reset mid-vector
    send0(16'h3F80, 1'b0);
    send0(16'h4000, 1'b0);
    check_eq("mid_cnt", {16'd0, beat_cnt0}, 32'd2);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_eq("mid_rst_valid", {31'd0, out_valid0}, 32'd0);
    check_eq("mid_rst_cnt", {16'd0, beat_cnt0}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    send0(16'h3F80, 1'b1);
    check_eq("post_rst_data", {16'd0, out_data0}, 32'h3F80);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/bfp16_accum.md
Name: bfp16_accum

Overview:
Downstream stage of the BFP16 multiplier in each systolic-array PE. It consumes a stream of BFP16 products (1-bit sign, 8-bit exponent, 7-bit fraction) and accumulates them into a running BFP16 sum. It emits one dot-product result per vector, with valid/ready handshakes on both sides. A vector ends either on an explicit last flag or after a fixed count of beats.

Parameters:
K_LEN, 0, beats per vector; 0 = vector ends only on in_last; N>0 = auto-terminate after N accepted beats (in_last also honoured)
CNT_W, 16, width of beat counter; must hold K_LEN

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-low reset
in_valid  input  1  product beat valid
in_ready  output  1  block can accept a beat
in_data  input  16  BFP16 product from multiplier
in_last  input  1  final beat of vector
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
out_data  output  16  BFP16 accumulated result
beat_cnt  output  CNT_W  beats accepted in current vector

Behaviour:
- Reset (rst=0, async): acc=16'h0000, beat_cnt=0, out_valid=0, out_data=16'h0000. in_ready is combinational; it reads 1 out of reset.
- Beat accepted when in_valid && in_ready.
- in_ready = !out_valid || out_ready. The block stalls only while a result is held and not taken.
- Per accepted beat: sum = fadd(acc, in_data), computed combinationally in one cycle; beat_cnt increments.
- Terminal beat: an accepted beat with in_last=1, or with K_LEN>0 && beat_cnt==K_LEN-1.
  - On a non-terminal beat: acc<=sum.
  - On a terminal beat: out_data<=sum, out_valid<=1, acc<=0, beat_cnt<=0.
- Latency: out_valid rises the cycle after the terminal beat.
- A new vector may begin that same cycle.
- Output holding:
  - out_valid && !out_ready: out_data is held stable and in_ready=0.
  - out_valid && out_ready with no new terminal beat: out_valid<=0 next cycle.
  - out_ready=1 and a new terminal beat accepted in the same cycle: out_valid stays 1 and out_data takes the new sum (back-to-back results, no bubble).
- fadd rules:
  - An exponent of 0 is treated as zero (subnormals flushed).
  - Align the smaller operand by right-shifting its mantissa {1,frac} extended with 3 guard bits. Shift saturates at 11.
  - Add or subtract by sign, then normalise: shift left/right and adjust the exponent.
  - Truncate the guard bits (round toward zero, consistent with the multiplier).
  - Exact cancellation gives +0 (16'h0000).
  - Result exponent >=255 gives signed inf ({s,8'hFF,7'h0}).
  - Result exponent <=0 gives signed zero.
- Specials:
  - Any NaN operand (exp=255, frac!=0) gives canonical NaN 16'h7FC0.
  - inf + (-inf) gives 16'h7FC0.
  - inf + finite gives that inf.
  - Once acc is NaN or inf, it is sticky until the vector terminates.
- A zero product is accepted and counted like any other beat.
- Reset mid-vector discards the partial acc and any held result; no output is produced for that vector.
- in_last on beat 1 is a single-beat vector: out_data = fadd(0, in_data), i.e. in_data with subnormals flushed.
- K_LEN>0 with in_last asserted early: vector ends at in_last and the counter clears.
- beat_cnt does not wrap within a vector when K_LEN>0. When K_LEN=0 it wraps modulo 2^CNT_W with no side effect.

Test Plan:
- K_LEN=0: beats 16'h3F80 (1.0), 16'h4000 (2.0), 16'h4040 (3.0, last), out_ready=1 -> out_data=16'h40C0 (6.0); out_valid high exactly 1 cycle, the cycle after the last beat.
- Cancellation: 16'h3F80 then 16'hBF80 (last) -> out_data=16'h0000. Overflow: 16'h7F7F + 16'h7F7F (last) -> 16'h7F80.
- Specials: 16'h7F80 + 16'hFF80 (last) -> 16'h7FC0. 16'h3F80 + 16'h7FC1 (last) -> 16'h7FC0. 16'h0001 (subnormal, last) -> 16'h0000.
- K_LEN=4, in_last tied 0: four beats of 16'h3F00 (0.5) -> 16'h4000. Next four beats of 16'h3F80 -> 16'h4080, back-to-back with no idle cycle.
- Backpressure: result 16'h40C0 pending with out_ready=0 for 5 cycles -> in_ready=0, out_data stable, driven beats not accepted. Raise out_ready -> result handed off, in_ready=1 in the same cycle.
- Reset: assert rst=0 after 2 of 3 beats (acc=3.0) -> out_valid=0 and beat_cnt=0 immediately. After release, beats 16'h3F80 (last) -> 16'h3F80.
